// File: rtl/decode_instr_queue.sv
// decode_instr_queue
//    Circular-buffer instruction queue between fetch and decode. Holds up to
//    DEPTH entries (instruction, PC, PC+4, predicted target, BTB way, taken
//    bit) so fetch can keep running while decode stalls. A flush empties the
//    queue in one cycle.
//
// Ports
//    i_clk, i_arst            clock (rising edge), async reset (active low)
//    i_flush                  drop all entries; wins over push and pop
//    i_valid / o_ready        fetch-side handshake and entry payload (i_*)
//    o_valid / i_ready        decode-side handshake and head payload (o_*)
//    o_count, o_empty, o_full occupancy status
module decode_instr_queue #(
   parameter int ADDR_WIDTH  = 64,
   parameter int INSTR_WIDTH = 32,
   parameter int BTB_WAY_W   = 2,
   parameter int DEPTH       = 4,
   parameter int CNT_W       = $clog2(DEPTH + 1)
) (
   input  logic                   i_clk,
   input  logic                   i_arst,
   input  logic                   i_flush,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [INSTR_WIDTH-1:0] i_instruction,
   input  logic [ADDR_WIDTH-1:0]  i_pc,
   input  logic [ADDR_WIDTH-1:0]  i_pc_plus4,
   input  logic [ADDR_WIDTH-1:0]  i_pc_target_pred,
   input  logic [BTB_WAY_W-1:0]   i_btb_way,
   input  logic                   i_branch_pred_taken,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [INSTR_WIDTH-1:0] o_instruction,
   output logic [ADDR_WIDTH-1:0]  o_pc,
   output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
   output logic [ADDR_WIDTH-1:0]  o_pc_target_pred,
   output logic [BTB_WAY_W-1:0]   o_btb_way,
   output logic                   o_branch_pred_taken,
   output logic [CNT_W-1:0]       o_count,
   output logic                   o_empty,
   output logic                   o_full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_WIDTH'(32'h0000_0013);

   logic [INSTR_WIDTH-1:0] mem_instr [DEPTH];
   logic [ADDR_WIDTH-1:0]  mem_pc    [DEPTH];
   logic [ADDR_WIDTH-1:0]  mem_pc4   [DEPTH];
   logic [ADDR_WIDTH-1:0]  mem_tgt   [DEPTH];
   logic [BTB_WAY_W-1:0]   mem_way   [DEPTH];
   logic                   mem_taken [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;

   // Full/empty come from the count so pointer equality is never ambiguous.
   assign o_full  = (count == FULL_CNT);
   assign o_empty = (count == '0);
   assign o_ready = !o_full;
   assign o_valid = !o_empty;
   assign o_count = count;

   assign push = i_valid & o_ready;
   assign pop  = o_valid & i_ready;

   always_ff @(posedge i_clk or negedge i_arst) begin
      if (!i_arst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_instr[i] <= '0;
            mem_pc[i]    <= '0;
            mem_pc4[i]   <= '0;
            mem_tgt[i]   <= '0;
            mem_way[i]   <= '0;
            mem_taken[i] <= 1'b0;
         end
      end else if (i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem_instr[wr_ptr] <= i_instruction;
            mem_pc[wr_ptr]    <= i_pc;
            mem_pc4[wr_ptr]   <= i_pc_plus4;
            mem_tgt[wr_ptr]   <= i_pc_target_pred;
            mem_way[wr_ptr]   <= i_btb_way;
            mem_taken[wr_ptr] <= i_branch_pred_taken;
            wr_ptr            <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // Empty queue presents a NOP bubble so decode never sees stale data.
   always_comb begin
      o_instruction       = NOP_INSTR;
      o_pc                = '0;
      o_pc_plus4          = '0;
      o_pc_target_pred    = '0;
      o_btb_way           = '0;
      o_branch_pred_taken = 1'b0;
      if (o_valid) begin
         o_instruction       = mem_instr[rd_ptr];
         o_pc                = mem_pc[rd_ptr];
         o_pc_plus4          = mem_pc4[rd_ptr];
         o_pc_target_pred    = mem_tgt[rd_ptr];
         o_btb_way           = mem_way[rd_ptr];
         o_branch_pred_taken = mem_taken[rd_ptr];
      end
   end

endmodule

// File: tb/tb_decode_instr_queue.sv
// Testbench for decode_instr_queue: directed scenarios followed by a random
// phase, all checked against a queue-based reference model.
module tb_decode_instr_queue;

   localparam int AW    = 64;
   localparam int IW    = 32;
   localparam int WW    = 2;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   typedef struct {
      logic [IW-1:0] instr;
      logic [AW-1:0] pc;
      logic [AW-1:0] pc4;
      logic [AW-1:0] tgt;
      logic [WW-1:0] way;
      logic          taken;
   } ent_t;

   logic          i_clk = 1'b0;
   logic          i_arst;
   logic          i_flush;
   logic          i_valid;
   logic          o_ready;
   logic [IW-1:0] i_instruction;
   logic [AW-1:0] i_pc;
   logic [AW-1:0] i_pc_plus4;
   logic [AW-1:0] i_pc_target_pred;
   logic [WW-1:0] i_btb_way;
   logic          i_branch_pred_taken;
   logic          o_valid;
   logic          i_ready;
   logic [IW-1:0] o_instruction;
   logic [AW-1:0] o_pc;
   logic [AW-1:0] o_pc_plus4;
   logic [AW-1:0] o_pc_target_pred;
   logic [WW-1:0] o_btb_way;
   logic          o_branch_pred_taken;
   logic [CW-1:0] o_count;
   logic          o_empty;
   logic          o_full;

   decode_instr_queue #(
      .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .BTB_WAY_W(WW), .DEPTH(DEPTH)
   ) dut (
      .i_clk(i_clk), .i_arst(i_arst), .i_flush(i_flush),
      .i_valid(i_valid), .o_ready(o_ready),
      .i_instruction(i_instruction), .i_pc(i_pc), .i_pc_plus4(i_pc_plus4),
      .i_pc_target_pred(i_pc_target_pred), .i_btb_way(i_btb_way),
      .i_branch_pred_taken(i_branch_pred_taken),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_instruction(o_instruction), .o_pc(o_pc), .o_pc_plus4(o_pc_plus4),
      .o_pc_target_pred(o_pc_target_pred), .o_btb_way(o_btb_way),
      .o_branch_pred_taken(o_branch_pred_taken),
      .o_count(o_count), .o_empty(o_empty), .o_full(o_full)
   );

   always #5 i_clk = ~i_clk;

   int   tests = 0;
   int   fails = 0;
   ent_t model_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic ent_t mk(input logic [AW-1:0] pc, input logic [IW-1:0] instr);
      ent_t e;
      e.instr = instr;
      e.pc    = pc;
      e.pc4   = pc + 64'd4;
      e.tgt   = '0;
      e.way   = '0;
      e.taken = 1'b0;
      return e;
   endfunction

   task automatic check_all(input string tag);
      ent_t h;
      int   n;
      n = model_q.size();
      if (n > 0) h = model_q[0];
      else begin
         h = mk(64'd0, 32'h0000_0013);
         h.pc4 = '0;
      end
      check({tag, "_count"}, 64'(o_count), 64'(n));
      check({tag, "_valid"}, 64'(o_valid), 64'(n > 0));
      check({tag, "_ready"}, 64'(o_ready), 64'(n < DEPTH));
      check({tag, "_empty"}, 64'(o_empty), 64'(n == 0));
      check({tag, "_full"},  64'(o_full),  64'(n == DEPTH));
      check({tag, "_instr"}, 64'(o_instruction), 64'(h.instr));
      check({tag, "_pc"},    o_pc, h.pc);
      check({tag, "_pc4"},   o_pc_plus4, h.pc4);
      check({tag, "_tgt"},   o_pc_target_pred, h.tgt);
      check({tag, "_way"},   64'(o_btb_way), 64'(h.way));
      check({tag, "_taken"}, 64'(o_branch_pred_taken), 64'(h.taken));
   endtask

   // Drive one cycle of inputs, advance the model by the queue rules, check.
   task automatic step(input string tag, input logic v, input ent_t e,
                       input logic r, input logic fl);
      logic do_push;
      logic do_pop;
      i_valid             = v;
      i_ready             = r;
      i_flush             = fl;
      i_instruction       = e.instr;
      i_pc                = e.pc;
      i_pc_plus4          = e.pc4;
      i_pc_target_pred    = e.tgt;
      i_btb_way           = e.way;
      i_branch_pred_taken = e.taken;
      do_push = v && (model_q.size() < DEPTH);
      do_pop  = r && (model_q.size() > 0);
      @(posedge i_clk);
      #1;
      if (fl) model_q.delete();
      else begin
         if (do_pop) void'(model_q.pop_front());
         if (do_push) model_q.push_back(e);
      end
      check_all(tag);
   endtask

   ent_t idle;
   ent_t e;
   ent_t pend;
   logic pend_v;
   logic v, r, fl;

   initial begin
      idle    = mk(64'd0, 32'd0);
      i_arst  = 1'b0;
      i_flush = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_instruction = '0; i_pc = '0; i_pc_plus4 = '0; i_pc_target_pred = '0;
      i_btb_way = '0; i_branch_pred_taken = 1'b0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_arst = 1'b1;
      #1;
      check_all("reset");

      // Push three with decode stalled.
      step("push0", 1'b1, mk(64'h1000, 32'h0050_0093), 1'b0, 1'b0);
      step("push1", 1'b1, mk(64'h1004, 32'h00A0_0113), 1'b0, 1'b0);
      step("push2", 1'b1, mk(64'h1008, 32'h0020_81B3), 1'b0, 1'b0);
      check("three_count", 64'(o_count), 64'd3);
      check("three_pc", o_pc, 64'h1000);
      check("three_instr", 64'(o_instruction), 64'h0050_0093);

      // Fill, then a refused fifth push.
      step("push3", 1'b1, mk(64'h100C, 32'h0000_0033), 1'b0, 1'b0);
      check("full_flag", 64'(o_full), 64'd1);
      step("push4_refused", 1'b1, mk(64'h1010, 32'h0000_0073), 1'b0, 1'b0);
      check("full_hold_count", 64'(o_count), 64'd4);

      // Full with simultaneous pop: push still refused.
      step("full_pop", 1'b1, mk(64'h1010, 32'h0000_0073), 1'b1, 1'b0);
      check("full_pop_count", 64'(o_count), 64'd3);
      check("full_pop_pc", o_pc, 64'h1004);
      for (int i = 0; i < 3; i++) step("drain", 1'b0, idle, 1'b1, 1'b0);
      check("drained_empty", 64'(o_empty), 64'd1);
      check("drained_nop", 64'(o_instruction), 64'h13);

      // Steady push+pop from count 2, wrapping pointers.
      step("pre0", 1'b1, mk(64'h4000, 32'h1), 1'b0, 1'b0);
      step("pre1", 1'b1, mk(64'h4004, 32'h2), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step("stream", 1'b1, mk(64'h4008 + 64'(4 * i), 32'(i + 3)), 1'b1, 1'b0);
         check("stream_pc", o_pc, 64'h4000 + 64'(4 * (i + 1)));
      end
      check("stream_count", 64'(o_count), 64'd2);

      // Flush beats push and pop.
      step("fill3", 1'b1, mk(64'h5000, 32'h11), 1'b0, 1'b0);
      check("pre_flush_count", 64'(o_count), 64'd3);
      step("flush", 1'b1, mk(64'h2FFC, 32'h99), 1'b1, 1'b1);
      check("flush_count", 64'(o_count), 64'd0);
      check("flush_valid", 64'(o_valid), 64'd0);
      step("post_flush", 1'b1, mk(64'h3000, 32'h55), 1'b0, 1'b0);
      check("post_flush_pc", o_pc, 64'h3000);
      step("post_flush_pop", 1'b0, idle, 1'b1, 1'b0);

      // Metadata carried to the head, cleared to bubble after pop.
      e = mk(64'h6000, 32'h0000_0063);
      e.tgt = 64'h2000; e.way = 2'b10; e.taken = 1'b1;
      step("meta_push", 1'b1, e, 1'b0, 1'b0);
      check("meta_tgt", o_pc_target_pred, 64'h2000);
      check("meta_way", 64'(o_btb_way), 64'd2);
      check("meta_taken", 64'(o_branch_pred_taken), 64'd1);
      step("meta_pop", 1'b0, idle, 1'b1, 1'b0);
      check("meta_tgt_clr", o_pc_target_pred, 64'd0);
      check("meta_taken_clr", 64'(o_branch_pred_taken), 64'd0);

      // Asynchronous reset mid-operation.
      for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, mk(64'h7000 + 64'(4 * i), 32'(i)), 1'b0, 1'b0);
      i_valid = 1'b0;
      #2;
      i_arst = 1'b0;
      #1;
      model_q.delete();
      check("arst_valid", 64'(o_valid), 64'd0);
      check("arst_count", 64'(o_count), 64'd0);
      check("arst_ready", 64'(o_ready), 64'd1);
      @(negedge i_clk);
      i_arst = 1'b1;
      #1;
      check_all("after_arst");

      // Random traffic; payload held while an offer is outstanding.
      pend_v = 1'b0;
      pend   = idle;
      for (int i = 0; i < 400; i++) begin
         if (pend_v) begin
            v = 1'b1;
            e = pend;
         end else begin
            v = ($urandom_range(0, 3) != 0);
            e.instr = $urandom();
            e.pc    = {$urandom(), $urandom()};
            e.pc4   = e.pc + 64'd4;
            e.tgt   = {$urandom(), $urandom()};
            e.way   = WW'($urandom());
            e.taken = 1'($urandom());
         end
         r  = ($urandom_range(0, 2) != 0);
         fl = ($urandom_range(0, 29) == 0);
         pend_v = v && !fl && (model_q.size() >= DEPTH);
         pend   = e;
         step("rand", v, e, r, fl);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
